// File: rtl/complex_mag_stream_hls_deadlock_monitor_gen2_pkg.sv
// Shared types and helpers for the complex_mag_stream HLS deadlock monitor.
//   state_t : monitor FSM states (IDLE, WATCH, BLOCKED), 2-bit encoding
//   src_w() : width of a source index for a given number of sources (min 1)
package complex_mag_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/complex_mag_stream_hls_deadlock_monitor_gen2_src_enc.sv
// Lowest-index priority encoder over the blocking-source vector.
//   vec : per-source blocked flags
//   idx : index of the lowest set bit (0 when none set)
//   any : OR of all bits
module complex_mag_deadlock_src_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !any) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/complex_mag_stream_hls_deadlock_monitor_gen2.sv
// Persistence-qualified deadlock monitor for HLS stream instances.
// A blocked condition (any AXIS block, or any non-idle blocked sub-instance)
// must hold for THRESHOLD consecutive cycles before block asserts. A sticky
// flag and the index of the first blocking source are kept until clear.
//   clock           : rising-edge clock
//   reset           : synchronous, active-low
//   clear           : pulse, clears block_sticky / first_src (and block_cycles)
//   axis_block_sigs : per-AXIS-channel blocked
//   inst_idle_sigs  : per-instance idle
//   inst_block_sigs : per-instance blocked
//   block           : registered persistent-block indication
//   block_sticky    : set on entry to blocked, held until clear
//   first_src       : source index captured with the sticky flag
//   block_cycles    : saturating count of block cycles, present only when
//                     COMPLEX_MAG_DEADLOCK_CYCLE_CNT_EN is defined
module complex_mag_stream_hls_deadlock_monitor_gen2
  import complex_mag_deadlock_pkg::*;
#(
  parameter  int NUM_AXIS  = 3,
  parameter  int NUM_INST  = 1,
  parameter  int THRESHOLD = 1,
  parameter  int CNT_W     = 16,
  localparam int SRC_W     = src_w(NUM_AXIS + NUM_INST),
  localparam int INST_W    = (NUM_INST > 0) ? NUM_INST : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [INST_W-1:0]   inst_idle_sigs,
  input  logic [INST_W-1:0]   inst_block_sigs,
  output logic                block,
  output logic                block_sticky,
`ifdef COMPLEX_MAG_DEADLOCK_CYCLE_CNT_EN
  output logic [SRC_W-1:0]    first_src,
  output logic [CNT_W-1:0]    block_cycles
`else
  output logic [SRC_W-1:0]    first_src
`endif
);

  localparam int NSRC = NUM_AXIS + NUM_INST;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);

  logic [NSRC-1:0]  src;
  logic [SRC_W-1:0] low_idx;
  logic             cur_block;
  logic             enter_blocked;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  generate
    if (NUM_INST > 0) begin : g_inst
      // An idle instance never counts as blocking.
      assign src = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs};
    end else begin : g_no_inst
      logic unused_inst;
      assign unused_inst = ^{inst_block_sigs, inst_idle_sigs};
      assign src         = axis_block_sigs;
    end
  endgenerate

  complex_mag_deadlock_src_enc #(
    .N (NSRC),
    .W (SRC_W)
  ) u_src_enc (
    .vec (src),
    .idx (low_idx),
    .any (cur_block)
  );

  // Transition into BLOCKED this cycle; drives the sticky capture.
  always_comb begin
    enter_blocked = 1'b0;
    if (cur_block) begin
      if (state == IDLE && THRESHOLD == 1)   enter_blocked = 1'b1;
      if (state == WATCH && cnt == CNT_LAST) enter_blocked = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      block        <= 1'b0;
      block_sticky <= 1'b0;
      first_src    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cur_block && THRESHOLD == 1) begin
            state <= BLOCKED;
            block <= 1'b1;
          end else if (cur_block) begin
            state <= WATCH;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        WATCH: begin
          if (!cur_block) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= BLOCKED;
            block <= 1'b1;
          end else begin
            cnt   <= cnt + CNT_W'(1);
          end
        end
        BLOCKED: begin
          if (!cur_block) begin
            state <= IDLE;
            cnt   <= '0;
            block <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          block <= 1'b0;
        end
      endcase

      // Capture has priority over a coincident clear.
      if (enter_blocked && !block_sticky) begin
        block_sticky <= 1'b1;
        first_src    <= low_idx;
      end else if (clear) begin
        block_sticky <= 1'b0;
        first_src    <= '0;
      end
    end
  end

`ifdef COMPLEX_MAG_DEADLOCK_CYCLE_CNT_EN
  // Clear then increment in the same cycle yields 1.
  always_ff @(posedge clock) begin
    if (!reset) begin
      block_cycles <= '0;
    end else if (clear) begin
      block_cycles <= block ? CNT_W'(1) : '0;
    end else if (block && block_cycles != '1) begin
      block_cycles <= block_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_complex_mag_stream_hls_deadlock_monitor_gen2.sv
// Self-checking bench: two monitors (THRESHOLD=1 and THRESHOLD=4) share the
// same stimulus; a run-length reference model predicts each output.
module tb_complex_mag_stream_hls_deadlock_monitor_gen2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] axis_block_sigs = '0;
  logic [0:0] inst_idle_sigs  = '0;
  logic [0:0] inst_block_sigs = '0;

  logic       block   [2];
  logic       sticky  [2];
  logic [1:0] fsrc    [2];
`ifdef COMPLEX_MAG_DEADLOCK_CYCLE_CNT_EN
  logic [3:0]  bcyc0;
  logic [15:0] bcyc1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  complex_mag_stream_hls_deadlock_monitor_gen2 #(
    .NUM_AXIS  (3),
    .NUM_INST  (1),
    .THRESHOLD (1),
    .CNT_W     (4)
  ) u_dut_t1 (
    .clock           (clock),
    .reset           (reset),
    .clear           (clear),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block[0]),
    .block_sticky    (sticky[0]),
`ifdef COMPLEX_MAG_DEADLOCK_CYCLE_CNT_EN
    .first_src       (fsrc[0]),
    .block_cycles    (bcyc0)
`else
    .first_src       (fsrc[0])
`endif
  );

  complex_mag_stream_hls_deadlock_monitor_gen2 #(
    .NUM_AXIS  (3),
    .NUM_INST  (1),
    .THRESHOLD (4),
    .CNT_W     (16)
  ) u_dut_t4 (
    .clock           (clock),
    .reset           (reset),
    .clear           (clear),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block[1]),
    .block_sticky    (sticky[1]),
`ifdef COMPLEX_MAG_DEADLOCK_CYCLE_CNT_EN
    .first_src       (fsrc[1]),
    .block_cycles    (bcyc1)
`else
    .first_src       (fsrc[1])
`endif
  );

  // Reference model state, per instance.
  int thr      [2] = '{1, 4};
  int bc_max   [2] = '{15, 65535};
  int run      [2];
  int m_block  [2];
  int m_sticky [2];
  int m_fsrc   [2];
  int m_bc     [2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_src(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic model_update();
    logic [3:0] s;
    int nb;
    s = {inst_block_sigs[0] & ~inst_idle_sigs[0], axis_block_sigs};
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        run[k] = 0; m_block[k] = 0; m_sticky[k] = 0; m_fsrc[k] = 0; m_bc[k] = 0;
      end else begin
        if (clear)
          m_bc[k] = m_block[k];
        else if (m_block[k] != 0 && m_bc[k] < bc_max[k])
          m_bc[k] = m_bc[k] + 1;
        run[k] = (s != 0) ? ((run[k] < 1000) ? run[k] + 1 : 1000) : 0;
        nb = (run[k] >= thr[k]) ? 1 : 0;
        if (nb == 1 && m_block[k] == 0 && m_sticky[k] == 0) begin
          m_sticky[k] = 1;
          m_fsrc[k]   = lowest_src(s);
        end else if (clear) begin
          m_sticky[k] = 0;
          m_fsrc[k]   = 0;
        end
        m_block[k] = nb;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("block[t%0d]", thr[k]), int'(block[k]), m_block[k]);
      check($sformatf("sticky[t%0d]", thr[k]), int'(sticky[k]), m_sticky[k]);
      check($sformatf("first_src[t%0d]", thr[k]), int'(fsrc[k]), m_fsrc[k]);
    end
`ifdef COMPLEX_MAG_DEADLOCK_CYCLE_CNT_EN
    check("block_cycles[t1]", int'(bcyc0), m_bc[0]);
    check("block_cycles[t4]", int'(bcyc1), m_bc[1]);
`endif
  endtask

  task automatic cyc(input logic [2:0] a, input logic ii, input logic ib,
                     input logic c, input logic r);
    @(negedge clock);
    axis_block_sigs = a;
    inst_idle_sigs  = ii;
    inst_block_sigs = ib;
    clear           = c;
    reset           = r;
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic cycn(input int n, input logic [2:0] a, input logic ii,
                      input logic ib);
    for (int i = 0; i < n; i++) cyc(a, ii, ib, 1'b0, 1'b1);
  endtask

  initial begin
    logic [2:0] ra;
    logic       rii, rib;

    for (int i = 0; i < 3; i++) cyc(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-cycle block on source 1.
    cyc(3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    cycn(3, 3'b000, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Burst of 3, gap, burst of 4 on source 0.
    cycn(3, 3'b001, 1'b0, 1'b0);
    cycn(1, 3'b000, 1'b0, 1'b0);
    cycn(4, 3'b001, 1'b0, 1'b0);
    cycn(2, 3'b000, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Idle instance never blocks; then it does.
    cycn(10, 3'b000, 1'b1, 1'b1);
    cycn(5, 3'b000, 1'b0, 1'b1);
    cycn(2, 3'b000, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);

    // First source kept across episodes; clear; clear racing a capture.
    cycn(5, 3'b100, 1'b0, 1'b0);
    cycn(2, 3'b000, 1'b0, 1'b0);
    cycn(5, 3'b001, 1'b0, 1'b0);
    cycn(1, 3'b000, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(3'b001, 1'b0, 1'b0, 1'b1, 1'b1);
    cycn(2, 3'b001, 1'b0, 1'b0);
    cyc(3'b001, 1'b0, 1'b0, 1'b1, 1'b1);
    cycn(2, 3'b000, 1'b0, 1'b0);

    // Long hold (saturation), clear while blocked, reset while blocked.
    cycn(20, 3'b011, 1'b0, 1'b0);
    cyc(3'b011, 1'b0, 1'b0, 1'b1, 1'b1);
    cycn(2, 3'b011, 1'b0, 1'b0);
    cyc(3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
    cycn(6, 3'b011, 1'b0, 1'b0);
    cycn(2, 3'b000, 1'b0, 1'b0);

    // Randomized traffic with sticky runs, clears and occasional resets.
    ra = '0; rii = 1'b0; rib = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < 3; b++) ra[b] = ($urandom_range(0, 3) == 0);
        rii = ($urandom_range(0, 1) == 0);
        rib = ($urandom_range(0, 2) == 0);
      end
      cyc(ra, rii, rib, ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 99) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
